// File: rtl/wash_phase_sequencer.sv
// Wash-program sequencer: steps FILL/WASH/DRAIN, FILL/RINSE/DRAIN and SPIN on a 1 s tick,
// with lid pause/resume, fill/drain timeouts latching FAULT, and an end-of-program beep.
module wash_phase_sequencer #(
  parameter int FILL_TMO  = 8,
  parameter int DRAIN_TMO = 8,
  parameter int BEEP_SECS = 3
) (
  input  logic       clk,
  input  logic       resetBtn,
  input  logic       tick_1s,
  input  logic       start,
  input  logic       lid_open,
  input  logic [2:0] mode,
  input  logic [2:0] wash_time,
  input  logic [2:0] rinse_time,
  input  logic [2:0] spin_time,
  input  logic       level_full,
  input  logic       level_empty,
  output logic       valve_in,
  output logic       motor_wash,
  output logic       drain_out,
  output logic       motor_spin,
  output logic [2:0] state,
  output logic [3:0] remaining,
  output logic       busy,
  output logic       beep,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FILL  = 4'd1,
    S_WASH  = 4'd2,
    S_RINSE = 4'd3,
    S_DRAIN = 4'd4,
    S_SPIN  = 4'd5,
    S_PAUSE = 4'd6,
    S_DONE  = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  localparam logic [3:0] FILL_LAST  = 4'(FILL_TMO - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_TMO - 1);
  localparam logic [3:0] BEEP_LAST  = 4'(BEEP_SECS - 1);

  state_t     state_q, state_d, ret_q, ret_d;
  logic       wash_pend_q, wash_pend_d, rinse_pend_q, rinse_pend_d, spin_pend_q, spin_pend_d;
  logic [2:0] wash_t_q, wash_t_d, rinse_t_q, rinse_t_d, spin_t_q, spin_t_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] cnt_q, cnt_d;

  // A programmed duration of zero still runs the phase for one tick.
  function automatic logic [3:0] load_time(input logic [2:0] t);
    return (t == 3'd0) ? 4'd1 : {1'b0, t};
  endfunction

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    wash_pend_d  = wash_pend_q;
    rinse_pend_d = rinse_pend_q;
    spin_pend_d  = spin_pend_q;
    wash_t_d     = wash_t_q;
    rinse_t_d    = rinse_t_q;
    spin_t_d     = spin_t_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && (mode != 3'd0) && !lid_open) begin
          {wash_pend_d, rinse_pend_d, spin_pend_d} = mode;
          wash_t_d  = wash_time;
          rinse_t_d = rinse_time;
          spin_t_d  = spin_time;
          cnt_d     = 4'd0;
          if (mode[2] || mode[1]) begin
            state_d = S_FILL;
          end else begin
            state_d     = S_SPIN;
            spin_pend_d = 1'b0;
            rem_d       = load_time(spin_time);
          end
        end
      end
      S_FILL: begin
        if (lid_open) begin
          state_d = S_PAUSE;
          ret_d   = S_FILL;
        end else if (level_full) begin
          cnt_d = 4'd0;
          if (wash_pend_q) begin
            state_d     = S_WASH;
            wash_pend_d = 1'b0;
            rem_d       = load_time(wash_t_q);
          end else begin
            state_d      = S_RINSE;
            rinse_pend_d = 1'b0;
            rem_d        = load_time(rinse_t_q);
          end
        end else if (tick_1s) begin
          if (cnt_q == FILL_LAST) state_d = S_FAULT;
          else                    cnt_d   = cnt_q + 4'd1;
        end
      end
      S_WASH, S_RINSE, S_SPIN: begin
        if (lid_open) begin
          state_d = S_PAUSE;
          ret_d   = state_q;
        end else if (tick_1s) begin
          if (rem_q == 4'd1) begin
            rem_d   = 4'd0;
            cnt_d   = 4'd0;
            state_d = (state_q == S_SPIN) ? S_DONE : S_DRAIN;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
      end
      S_DRAIN: begin
        if (lid_open) begin
          state_d = S_PAUSE;
          ret_d   = S_DRAIN;
        end else if (level_empty) begin
          cnt_d = 4'd0;
          if (rinse_pend_q) begin
            state_d = S_FILL;
          end else if (spin_pend_q) begin
            state_d     = S_SPIN;
            spin_pend_d = 1'b0;
            rem_d       = load_time(spin_t_q);
          end else begin
            state_d = S_DONE;
          end
        end else if (tick_1s) begin
          if (cnt_q == DRAIN_LAST) state_d = S_FAULT;
          else                     cnt_d   = cnt_q + 4'd1;
        end
      end
      S_PAUSE: begin
        // Counters are left untouched so the saved phase resumes where it stopped.
        if (start && !lid_open) state_d = ret_q;
      end
      S_DONE: begin
        if (tick_1s) begin
          if (cnt_q == BEEP_LAST) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetBtn) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      wash_pend_q  <= 1'b0;
      rinse_pend_q <= 1'b0;
      spin_pend_q  <= 1'b0;
      wash_t_q     <= 3'd0;
      rinse_t_q    <= 3'd0;
      spin_t_q     <= 3'd0;
      rem_q        <= 4'd0;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      wash_pend_q  <= wash_pend_d;
      rinse_pend_q <= rinse_pend_d;
      spin_pend_q  <= spin_pend_d;
      wash_t_q     <= wash_t_d;
      rinse_t_q    <= rinse_t_d;
      spin_t_q     <= spin_t_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
    end
  end

  assign valve_in   = (state_q == S_FILL);
  assign motor_wash = (state_q == S_WASH) || (state_q == S_RINSE);
  assign drain_out  = (state_q == S_DRAIN) || (state_q == S_SPIN);
  assign motor_spin = (state_q == S_SPIN);
  assign state      = (state_q == S_FAULT) ? 3'd7 : state_q[2:0];
  assign remaining  = rem_q;
  assign busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAULT));
  assign beep       = (state_q == S_DONE);
  assign fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_wash_phase_sequencer.sv
// Bench for wash_phase_sequencer: directed program scenarios with fixed expectations, then
// random stimulus compared each cycle against a phase-list reference model.
module tb_wash_phase_sequencer;

  logic       clk;
  logic       resetBtn, tick_1s, start, lid_open, level_full, level_empty;
  logic [2:0] mode, wash_time, rinse_time, spin_time;
  logic       valve_in, motor_wash, drain_out, motor_spin, busy, beep, fault;
  logic [2:0] state;
  logic [3:0] remaining;

  int checks = 0;
  int errors = 0;

  wash_phase_sequencer dut (
    .clk(clk), .resetBtn(resetBtn), .tick_1s(tick_1s), .start(start), .lid_open(lid_open),
    .mode(mode), .wash_time(wash_time), .rinse_time(rinse_time), .spin_time(spin_time),
    .level_full(level_full), .level_empty(level_empty),
    .valve_in(valve_in), .motor_wash(motor_wash), .drain_out(drain_out), .motor_spin(motor_spin),
    .state(state), .remaining(remaining), .busy(busy), .beep(beep), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the program is a list of phases built at start; an index walks it.
  // Phase codes: 1 FILL 2 WASH 3 RINSE 4 DRAIN 5 SPIN 7 DONE.
  int prog[$];
  int dur[$];
  int m_idx = 0;
  int m_el = 0;
  bit m_idle = 1'b1;
  bit m_paused = 1'b0;
  bit m_fault = 1'b0;

  function automatic int secs(input logic [2:0] t);
    return (t == 3'd0) ? 1 : int'(t);
  endfunction

  task automatic model_step(input bit rst, input bit ts, input bit st, input bit lid,
                            input bit full, input bit empty);
    int cur;
    if (rst) begin
      m_idle = 1; m_fault = 0; m_paused = 0; m_idx = 0; m_el = 0;
      prog.delete(); dur.delete();
    end else if (m_fault) begin
      m_fault = 1;
    end else if (m_idle) begin
      if (st && mode != 3'd0 && !lid) begin
        prog.delete(); dur.delete();
        if (mode[2]) begin prog.push_back(1); prog.push_back(2); prog.push_back(4);
          dur.push_back(0); dur.push_back(secs(wash_time)); dur.push_back(0); end
        if (mode[1]) begin prog.push_back(1); prog.push_back(3); prog.push_back(4);
          dur.push_back(0); dur.push_back(secs(rinse_time)); dur.push_back(0); end
        if (mode[0]) begin prog.push_back(5); dur.push_back(secs(spin_time)); end
        prog.push_back(7); dur.push_back(0);
        m_idle = 0; m_idx = 0; m_el = 0;
      end
    end else begin
      cur = prog[m_idx];
      if (cur == 7) begin
        if (ts) begin m_el++; if (m_el == 3) m_idle = 1; end
      end else if (m_paused) begin
        if (st && !lid) m_paused = 0;
      end else if (lid) begin
        m_paused = 1;
      end else if (cur == 1 || cur == 4) begin
        if ((cur == 1 && full) || (cur == 4 && empty)) begin m_idx++; m_el = 0; end
        else if (ts) begin m_el++; if (m_el == 8) m_fault = 1; end
      end else if (ts) begin
        m_el++;
        if (m_el == dur[m_idx]) begin m_idx++; m_el = 0; end
      end
    end
  endtask

  function automatic int e_state();
    if (m_idle) return 0;
    if (m_fault) return 7;
    if (m_paused) return 6;
    return prog[m_idx];
  endfunction

  function automatic int e_rem();
    int cur;
    if (m_idle || m_fault) return 0;
    cur = prog[m_idx];
    if (cur == 2 || cur == 3 || cur == 5) return dur[m_idx] - m_el;
    return 0;
  endfunction

  // {valve_in, motor_wash, drain_out, motor_spin, busy, beep, fault}
  function automatic logic [6:0] e_flags();
    int  s;
    s = e_state();
    if (m_fault) return 7'b0000001;
    return {s == 1, s == 2 || s == 3, s == 4 || s == 5, s == 5,
            s != 0 && s != 7, s == 7, 1'b0};
  endfunction

  task automatic cyc(input bit rst, input bit ts, input bit st, input bit lid,
                     input bit full, input bit empty);
    resetBtn = rst; tick_1s = ts; start = st; lid_open = lid;
    level_full = full; level_empty = empty;
    @(posedge clk);
    model_step(rst, ts, st, lid, full, empty);
    #1;
  endtask

  task automatic one_sec(input bit lid);
    cyc(0, 0, 0, lid, 0, 0);
    cyc(0, 1, 0, lid, 0, 0);
  endtask

  task automatic set_prog(input logic [2:0] m, input logic [2:0] w, input logic [2:0] r,
                          input logic [2:0] s);
    mode = m; wash_time = w; rinse_time = r; spin_time = s;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++;
    if ({valve_in, motor_wash, drain_out, motor_spin, busy, beep, fault} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0", {valve_in, motor_wash, drain_out, motor_spin, busy, beep, fault});
    end
    checks++;
    if (remaining !== 4'd0) begin errors++; $display("FAIL reset_remaining: got %0d want 0", remaining); end
    checks++;
    $display("test_reset done");
  endtask

  task automatic test_full_program();
    set_prog(3'b111, 3'd2, 3'd1, 3'd3);
    cyc(0, 0, 1, 0, 0, 0);
    if (state !== 3'd1 || valve_in !== 1'b1) begin errors++; $display("FAIL prog_fill: state %0d valve %b want 1/1", state, valve_in); end
    checks++;
    one_sec(0); one_sec(0);
    cyc(0, 0, 0, 0, 1, 0);
    if (state !== 3'd2 || remaining !== 4'd2) begin errors++; $display("FAIL prog_wash: state %0d rem %0d want 2/2", state, remaining); end
    checks++;
    one_sec(0);
    if (remaining !== 4'd1) begin errors++; $display("FAIL prog_wash_rem: got %0d want 1", remaining); end
    checks++;
    one_sec(0);
    if (state !== 3'd4 || drain_out !== 1'b1) begin errors++; $display("FAIL prog_drain1: state %0d drain %b want 4/1", state, drain_out); end
    checks++;
    one_sec(0); one_sec(0);
    cyc(0, 0, 0, 0, 0, 1);
    if (state !== 3'd1) begin errors++; $display("FAIL prog_refill: got %0d want 1", state); end
    checks++;
    one_sec(0); one_sec(0);
    cyc(0, 0, 0, 0, 1, 0);
    if (state !== 3'd3 || remaining !== 4'd1 || motor_wash !== 1'b1) begin
      errors++; $display("FAIL prog_rinse: state %0d rem %0d motor %b want 3/1/1", state, remaining, motor_wash);
    end
    checks++;
    one_sec(0);
    cyc(0, 0, 0, 0, 0, 1);
    if (state !== 3'd5 || remaining !== 4'd3 || motor_spin !== 1'b1) begin
      errors++; $display("FAIL prog_spin: state %0d rem %0d spin %b want 5/3/1", state, remaining, motor_spin);
    end
    checks++;
    one_sec(0); one_sec(0); one_sec(0);
    if (state !== 3'd7 || beep !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL prog_done: state %0d beep %b busy %b want 7/1/0", state, beep, busy);
    end
    checks++;
    one_sec(0); one_sec(0);
    if (state !== 3'd7) begin errors++; $display("FAIL prog_beep_hold: got %0d want 7", state); end
    checks++;
    one_sec(0);
    if (state !== 3'd0 || beep !== 1'b0) begin errors++; $display("FAIL prog_idle: state %0d beep %b want 0/0", state, beep); end
    checks++;
    $display("test_full_program done");
  endtask

  task automatic test_spin_only();
    set_prog(3'b001, 3'd0, 3'd0, 3'd2);
    cyc(0, 0, 1, 0, 0, 0);
    if (state !== 3'd5 || drain_out !== 1'b1 || motor_spin !== 1'b1 || remaining !== 4'd2) begin
      errors++; $display("FAIL spin_entry: state %0d drain %b spin %b rem %0d want 5/1/1/2", state, drain_out, motor_spin, remaining);
    end
    checks++;
    one_sec(0);
    if (state !== 3'd5) begin errors++; $display("FAIL spin_first_tick: got %0d want 5", state); end
    checks++;
    one_sec(0);
    if (state !== 3'd7) begin errors++; $display("FAIL spin_done: got %0d want 7", state); end
    checks++;
    set_prog(3'b111, 3'd1, 3'd1, 3'd1);
    cyc(0, 0, 1, 0, 0, 0);
    if (state !== 3'd7 || remaining !== 4'd0) begin errors++; $display("FAIL start_in_done: state %0d rem %0d want 7/0", state, remaining); end
    checks++;
    one_sec(0); one_sec(0); one_sec(0);
    $display("test_spin_only done");
  endtask

  task automatic test_pause();
    set_prog(3'b100, 3'd3, 3'd0, 3'd0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0, 0);
    if (state !== 3'd6 || remaining !== 4'd3 || motor_wash !== 1'b0) begin
      errors++; $display("FAIL pause_entry: state %0d rem %0d motor %b want 6/3/0", state, remaining, motor_wash);
    end
    checks++;
    for (int i = 0; i < 5; i++) one_sec(1);
    cyc(0, 0, 1, 1, 0, 0);
    if (state !== 3'd6 || remaining !== 4'd3) begin errors++; $display("FAIL pause_hold: state %0d rem %0d want 6/3", state, remaining); end
    checks++;
    cyc(0, 1, 0, 0, 0, 0);
    if (state !== 3'd6) begin errors++; $display("FAIL pause_no_start: got %0d want 6", state); end
    checks++;
    cyc(0, 0, 1, 0, 0, 0);
    if (state !== 3'd2 || remaining !== 4'd3) begin errors++; $display("FAIL pause_resume: state %0d rem %0d want 2/3", state, remaining); end
    checks++;
    one_sec(0); one_sec(0);
    if (state !== 3'd2 || remaining !== 4'd1) begin errors++; $display("FAIL resume_count: state %0d rem %0d want 2/1", state, remaining); end
    checks++;
    one_sec(0);
    if (state !== 3'd4) begin errors++; $display("FAIL resume_drain: got %0d want 4", state); end
    checks++;
    cyc(0, 0, 0, 0, 0, 1);
    one_sec(0); one_sec(0); one_sec(0);
    $display("test_pause done");
  endtask

  task automatic test_fill_timeout();
    set_prog(3'b010, 3'd0, 3'd2, 3'd0);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) one_sec(0);
    if (state !== 3'd1 || valve_in !== 1'b1) begin errors++; $display("FAIL fill_7th_tick: state %0d valve %b want 1/1", state, valve_in); end
    checks++;
    one_sec(0);
    if (state !== 3'd7 || fault !== 1'b1 || valve_in !== 1'b0) begin
      errors++; $display("FAIL fill_fault: state %0d fault %b valve %b want 7/1/0", state, fault, valve_in);
    end
    checks++;
    cyc(0, 0, 1, 0, 1, 0);
    if (state !== 3'd7 || fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: state %0d fault %b want 7/1", state, fault); end
    checks++;
    cyc(1, 0, 0, 0, 0, 0);
    if (state !== 3'd0 || fault !== 1'b0) begin errors++; $display("FAIL fault_reset: state %0d fault %b want 0/0", state, fault); end
    checks++;
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) one_sec(0);
    cyc(0, 1, 0, 0, 1, 0);
    if (state !== 3'd3 || fault !== 1'b0) begin errors++; $display("FAIL full_beats_timeout: state %0d fault %b want 3/0", state, fault); end
    checks++;
    cyc(1, 0, 0, 0, 0, 0);
    $display("test_fill_timeout done");
  endtask

  task automatic test_reset_mid_spin();
    set_prog(3'b001, 3'd0, 3'd0, 3'd5);
    cyc(0, 0, 1, 0, 0, 0);
    one_sec(0);
    cyc(1, 1, 1, 0, 1, 1);
    if (state !== 3'd0 || {valve_in, motor_wash, drain_out, motor_spin} !== 4'b0 || remaining !== 4'd0) begin
      errors++; $display("FAIL reset_mid_spin: state %0d act %b rem %0d want 0/0/0", state, {valve_in, motor_wash, drain_out, motor_spin}, remaining);
    end
    checks++;
    $display("test_reset_mid_spin done");
  endtask

  task automatic test_ignored_start();
    set_prog(3'b000, 3'd3, 3'd3, 3'd3);
    cyc(0, 0, 1, 0, 0, 0);
    if (state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL start_mode0: state %0d busy %b want 0/0", state, busy); end
    checks++;
    set_prog(3'b111, 3'd3, 3'd3, 3'd3);
    cyc(0, 0, 1, 1, 0, 0);
    if (state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL start_lid_open: state %0d busy %b want 0/0", state, busy); end
    checks++;
    cyc(0, 0, 0, 0, 0, 0);
    $display("test_ignored_start done");
  endtask

  task automatic test_random();
    bit lid = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(29) == 0) lid = ~lid;
      set_prog(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      cyc($urandom_range(299) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0, lid,
          $urandom_range(5) == 0, $urandom_range(5) == 0);
      if (int'(state) !== e_state()) begin errors++; $display("FAIL rand_state cyc %0d: got %0d want %0d", n, state, e_state()); end
      checks++;
      if (int'(remaining) !== e_rem()) begin errors++; $display("FAIL rand_remaining cyc %0d: got %0d want %0d", n, remaining, e_rem()); end
      checks++;
      if ({valve_in, motor_wash, drain_out, motor_spin, busy, beep, fault} !== e_flags()) begin
        errors++; $display("FAIL rand_flags cyc %0d: got %b want %b", n, {valve_in, motor_wash, drain_out, motor_spin, busy, beep, fault}, e_flags());
      end
      checks++;
    end
    $display("test_random done");
  endtask

  initial begin
    resetBtn = 1'b1; tick_1s = 1'b0; start = 1'b0; lid_open = 1'b0;
    level_full = 1'b0; level_empty = 1'b0;
    set_prog(3'b000, 3'd0, 3'd0, 3'd0);
    test_reset();
    test_full_program();
    test_spin_only();
    test_pause();
    test_fill_timeout();
    test_reset_mid_spin();
    test_ignored_start();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
